// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: RAM handshake states, arbiter states and the word type.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    LG_I = 1'b0,
    LG_D = 1'b1
  } grant_t;

  // Watchdog counter width; a zero timeout still yields a legal 1-bit counter.
  function automatic int wdog_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-transaction arbiter between icache/dcache ports and a single-ported RAM.
// RAM-side signals are combinational from the current grant so address changes pass through.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit DATA_PRIO = 1'b1,
  parameter int TIMEOUT   = 64
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output word_t     iload,
  output logic      iwait,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output word_t     dload,
  output logic      dwait,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      bus_err
);

  localparam int TW = wdog_width(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  arb_state_t    r_state;
  grant_t        r_last;
  logic [TW-1:0] r_timer;

  logic w_dreq, w_in_i, w_in_d, w_granted, w_access, w_gnt_req;
  logic w_done, w_wdraw, w_err, w_tmo, w_pick_d;

  assign w_dreq    = dREN | dWEN;
  assign w_in_i    = (r_state == GNT_I);
  assign w_in_d    = (r_state == GNT_D);
  assign w_granted = w_in_i | w_in_d;
  assign w_access  = (ramstate == ACCESS);
  assign w_gnt_req = (w_in_i & iREN) | (w_in_d & w_dreq);

  // ACCESS wins over a same-cycle withdrawal; withdrawal suppresses any error report.
  assign w_done  = w_granted & w_access;
  assign w_wdraw = w_granted & ~w_access & ~w_gnt_req;
  assign w_err   = w_granted & ~w_access & w_gnt_req & (ramstate == ERROR);
  assign w_tmo   = WDOG_EN & w_granted & ~w_access & w_gnt_req & ~w_err
                 & (r_timer == TMO_LAST);

  // Data wins from IDLE unless round-robin says the icache is owed the slot.
  assign w_pick_d = w_dreq & (~iREN | DATA_PRIO | (r_last == LG_I));

  assign bus_err = w_err | w_tmo;
  assign iwait   = iREN   & ~(w_in_i & w_access);
  assign dwait   = w_dreq & ~(w_in_d & w_access);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    if (w_in_i) begin
      ramREN  = iREN;
      ramaddr = iaddr;
      if (w_access) iload = ramload;
    end else if (w_in_d) begin
      ramWEN  = dWEN;
      ramREN  = dREN & ~dWEN;
      ramaddr = daddr;
      if (dWEN) ramstore = dstore;
      if (w_access && !dWEN) dload = ramload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_last  <= LG_I;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_timer <= '0;
          if (w_pick_d) begin
            r_state <= GNT_D;
            r_last  <= LG_D;
          end else if (iREN) begin
            r_state <= GNT_I;
            r_last  <= LG_I;
          end
        end
        GNT_I, GNT_D: begin
          if (w_done || w_wdraw || w_err || w_tmo) begin
            r_state <= IDLE;
          end else if (WDOG_EN) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: two arbiters (data-priority and round-robin), watchdog of 4 cycles.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  typedef struct packed {
    logic  is_d;
    word_t data;
  } exp_t;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN[2], dREN[2], dWEN[2];
  word_t     iaddr[2], daddr[2], dstore[2], ramload[2];
  ramstate_t ramstate[2];
  word_t     iload[2], dload[2], ramaddr[2], ramstore[2];
  logic      iwait[2], dwait[2], ramREN[2], ramWEN[2], bus_err[2];

  exp_t q0[$], q1[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(4)) u0 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN[0]), .iaddr(iaddr[0]), .iload(iload[0]), .iwait(iwait[0]),
    .dREN(dREN[0]), .dWEN(dWEN[0]), .daddr(daddr[0]), .dstore(dstore[0]),
    .dload(dload[0]), .dwait(dwait[0]),
    .ramREN(ramREN[0]), .ramWEN(ramWEN[0]), .ramaddr(ramaddr[0]), .ramstore(ramstore[0]),
    .ramload(ramload[0]), .ramstate(ramstate[0]), .bus_err(bus_err[0])
  );

  mem_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(4)) u1 (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN[1]), .iaddr(iaddr[1]), .iload(iload[1]), .iwait(iwait[1]),
    .dREN(dREN[1]), .dWEN(dWEN[1]), .daddr(daddr[1]), .dstore(dstore[1]),
    .dload(dload[1]), .dwait(dwait[1]),
    .ramREN(ramREN[1]), .ramWEN(ramWEN[1]), .ramaddr(ramaddr[1]), .ramstore(ramstore[1]),
    .ramload(ramload[1]), .ramstate(ramstate[1]), .bus_err(bus_err[1])
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input logic is_d, input word_t d);
    exp_t e;
    e.is_d = is_d;
    e.data = d;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic sb_cmp(input int k, input logic is_d, input word_t got);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      chk($sformatf("sb_empty%0d", k), 32'(n), 32'd1);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("sb_port%0d", k), 32'(is_d), 32'(e.is_d));
      chk($sformatf("sb_load%0d", k), got, e.data);
    end
  endtask

  // Completion monitor: a requester whose wait drops has its transaction retired.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int k = 0; k < 2; k++) begin
        if (iREN[k] && !iwait[k]) sb_cmp(k, 1'b0, iload[k]);
        if ((dREN[k] || dWEN[k]) && !dwait[k]) sb_cmp(k, 1'b1, dload[k]);
      end
    end
  end

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    nRST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iREN[k] = 1'b0; dREN[k] = 1'b0; dWEN[k] = 1'b0;
      iaddr[k] = '0; daddr[k] = '0; dstore[k] = '0; ramload[k] = '0;
      ramstate[k] = FREE;
    end
    iREN[0] = 1'b1;
    #3;
    chk("rst_iwait",  32'(iwait[0]),   32'd1);
    chk("rst_dwait",  32'(dwait[0]),   32'd0);
    chk("rst_ramREN", 32'(ramREN[0]),  32'd0);
    chk("rst_buserr", 32'(bus_err[0]), 32'd0);
    chk("rst_addr",   ramaddr[0],      32'h0);
    iREN[0] = 1'b0;
    #9 nRST = 1'b1;

    // icache read, two BUSY cycles then ACCESS
    nxt(); iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate[0] = BUSY;
    push(0, 1'b0, 32'h2408_0001);
    smp(); chk("t1_c0_ren", 32'(ramREN[0]), 32'd0); chk("t1_c0_iwait", 32'(iwait[0]), 32'd1);
    nxt(); smp(); chk("t1_c1_ren", 32'(ramREN[0]), 32'd1); chk("t1_c1_addr", ramaddr[0], 32'h40);
    chk("t1_c1_iwait", 32'(iwait[0]), 32'd1);
    nxt(); smp(); chk("t1_c2_ren", 32'(ramREN[0]), 32'd1);
    nxt(); ramstate[0] = ACCESS; ramload[0] = 32'h2408_0001;
    smp(); chk("t1_c3_iwait", 32'(iwait[0]), 32'd0);
    nxt(); iREN[0] = 1'b0; ramstate[0] = FREE;
    smp(); chk("t1_c4_ren", 32'(ramREN[0]), 32'd0);

    // simultaneous requests, data priority
    nxt(); iREN[0] = 1'b1; iaddr[0] = 32'h80; dREN[0] = 1'b1; daddr[0] = 32'h100;
    ramstate[0] = ACCESS; ramload[0] = 32'h1111_2222;
    push(0, 1'b1, 32'h1111_2222); push(0, 1'b0, 32'h1111_2222);
    smp(); chk("t2_c0_ren", 32'(ramREN[0]), 32'd0); chk("t2_c0_dwait", 32'(dwait[0]), 32'd1);
    nxt(); smp(); chk("t2_c1_dwait", 32'(dwait[0]), 32'd0); chk("t2_c1_iwait", 32'(iwait[0]), 32'd1);
    chk("t2_c1_addr", ramaddr[0], 32'h100);
    nxt(); dREN[0] = 1'b0;
    smp(); chk("t2_c2_ren", 32'(ramREN[0]), 32'd0); chk("t2_c2_iwait", 32'(iwait[0]), 32'd1);
    nxt(); smp(); chk("t2_c3_iwait", 32'(iwait[0]), 32'd0); chk("t2_c3_addr", ramaddr[0], 32'h80);
    nxt(); iREN[0] = 1'b0; ramstate[0] = FREE;
    smp(); chk("t2_c4_ren", 32'(ramREN[0]), 32'd0);

    // round-robin: leave last_grant=D, then hold both requests for four grants
    nxt(); dREN[1] = 1'b1; daddr[1] = 32'h300; ramstate[1] = ACCESS; ramload[1] = 32'h3333_4444;
    push(1, 1'b1, 32'h3333_4444);
    nxt(); smp(); chk("t3_pre_addr", ramaddr[1], 32'h300);
    nxt(); dREN[1] = 1'b0;
    nxt(); iREN[1] = 1'b1; iaddr[1] = 32'h400; dREN[1] = 1'b1; daddr[1] = 32'h500;
    for (int j = 0; j < 4; j++) push(1, 1'(j % 2), 32'h3333_4444);
    for (int j = 0; j < 4; j++) begin
      nxt(); smp();
      chk($sformatf("t3_g%0d_addr", j), ramaddr[1], (j % 2 == 0) ? 32'h400 : 32'h500);
      chk($sformatf("t3_g%0d_ren", j), 32'(ramREN[1]), 32'd1);
      nxt();
      if (j == 3) begin iREN[1] = 1'b0; dREN[1] = 1'b0; ramstate[1] = FREE; end
      smp(); chk($sformatf("t3_i%0d_ren", j), 32'(ramREN[1]), 32'd0);
    end

    // write with both dWEN and dREN: write wins, load stays 0
    nxt(); dWEN[0] = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'hDEAD_BEEF;
    ramstate[0] = BUSY; ramload[0] = 32'h1234_5678;
    push(0, 1'b1, 32'h0);
    nxt(); smp(); chk("t4_wen", 32'(ramWEN[0]), 32'd1); chk("t4_ren", 32'(ramREN[0]), 32'd0);
    chk("t4_store", ramstore[0], 32'hDEAD_BEEF); chk("t4_addr", ramaddr[0], 32'h200);
    nxt(); ramstate[0] = ACCESS;
    smp(); chk("t4_dwait", 32'(dwait[0]), 32'd0);
    nxt(); dWEN[0] = 1'b0; dREN[0] = 1'b0; ramstate[0] = FREE;
    smp(); chk("t4_wen_off", 32'(ramWEN[0]), 32'd0);

    // watchdog: BUSY forever, bus_err only on the 4th grant cycle
    nxt(); iREN[0] = 1'b1; iaddr[0] = 32'h44; ramstate[0] = BUSY;
    for (int g = 1; g <= 4; g++) begin
      nxt(); smp();
      chk($sformatf("t5_g%0d_err", g), 32'(bus_err[0]), (g == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t5_g%0d_ren", g), 32'(ramREN[0]), 32'd1);
    end
    nxt(); smp(); chk("t5_idle_err", 32'(bus_err[0]), 32'd0);
    chk("t5_idle_ren", 32'(ramREN[0]), 32'd0); chk("t5_idle_iwait", 32'(iwait[0]), 32'd1);
    nxt(); ramstate[0] = ACCESS; ramload[0] = 32'h0000_0055; push(0, 1'b0, 32'h55);
    smp(); chk("t5_regrant", 32'(ramREN[0]), 32'd1);
    nxt(); iREN[0] = 1'b0; ramstate[0] = FREE;

    // RAM ERROR: one pulse, wait held, retry completes
    nxt(); iREN[0] = 1'b1; iaddr[0] = 32'h48; ramstate[0] = ERROR;
    smp(); chk("t6_c0_err", 32'(bus_err[0]), 32'd0);
    nxt(); smp(); chk("t6_c1_err", 32'(bus_err[0]), 32'd1); chk("t6_c1_iwait", 32'(iwait[0]), 32'd1);
    nxt(); ramstate[0] = BUSY;
    smp(); chk("t6_c2_err", 32'(bus_err[0]), 32'd0); chk("t6_c2_ren", 32'(ramREN[0]), 32'd0);
    nxt(); ramstate[0] = ACCESS; ramload[0] = 32'h0000_0066; push(0, 1'b0, 32'h66);
    smp(); chk("t6_c3_iwait", 32'(iwait[0]), 32'd0);
    nxt(); iREN[0] = 1'b0; ramstate[0] = FREE;

    // withdrawal mid-grant
    nxt(); dREN[0] = 1'b1; daddr[0] = 32'h600; ramstate[0] = BUSY;
    nxt(); smp(); chk("t7_c1_ren", 32'(ramREN[0]), 32'd1);
    nxt(); dREN[0] = 1'b0;
    smp(); chk("t7_c2_ren", 32'(ramREN[0]), 32'd0); chk("t7_c2_err", 32'(bus_err[0]), 32'd0);
    nxt(); ramstate[0] = FREE;

    // async reset during a write grant
    nxt(); dWEN[0] = 1'b1; daddr[0] = 32'h700; dstore[0] = 32'h0000_CAFE; ramstate[0] = BUSY;
    nxt(); smp(); chk("t8_wen", 32'(ramWEN[0]), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t8_rst_wen", 32'(ramWEN[0]), 32'd0); chk("t8_rst_err", 32'(bus_err[0]), 32'd0);
    chk("t8_rst_addr", ramaddr[0], 32'h0); chk("t8_rst_dwait", 32'(dwait[0]), 32'd1);
    nxt(); dWEN[0] = 1'b0;
    #2 nRST = 1'b1;
    nxt(); smp(); chk("t8_post_wen", 32'(ramWEN[0]), 32'd0);
    nxt(); dWEN[0] = 1'b1; ramstate[0] = ACCESS; push(0, 1'b1, 32'h0);
    smp(); chk("t8_idle_wen", 32'(ramWEN[0]), 32'd0);
    nxt(); smp(); chk("t8_regrant_wen", 32'(ramWEN[0]), 32'd1);
    nxt(); dWEN[0] = 1'b0; ramstate[0] = FREE;

    repeat (2) nxt();
    chk("sb_left0", 32'(q0.size()), 32'd0);
    chk("sb_left1", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
